// File: rtl/gpu_draw_sequencer_if.sv
// rtl/gpu_draw_sequencer_if.sv - command, sprite memory, framebuffer and scanout signals of the draw sequencer
interface gpu_draw_sequencer_if;
    logic [3:0]  gpu_cmd;
    logic [15:0] gpu_draw_offset;
    logic [7:0]  gpu_draw_x;
    logic [7:0]  gpu_draw_y;
    logic [7:0]  gpu_draw_length;
    logic        gpu_cmd_submitted;
    logic        gpu_ready;
    logic        gpu_collision;
    logic [15:0] mem_addr;
    logic        mem_rd_en;
    logic [7:0]  mem_rd_data;
    logic [7:0]  fb_addr;
    logic        fb_we;
    logic [7:0]  fb_wdata;
    logic [7:0]  fb_rdata;
    logic        scan_req;
    logic [7:0]  scan_addr;
    logic        scan_gnt;

    modport slave (
        input  gpu_cmd, gpu_draw_offset, gpu_draw_x, gpu_draw_y, gpu_draw_length,
               gpu_cmd_submitted, mem_rd_data, fb_rdata, scan_req, scan_addr,
        output gpu_ready, gpu_collision, mem_addr, mem_rd_en, fb_addr, fb_we,
               fb_wdata, scan_gnt
    );

    modport master (
        output gpu_cmd, gpu_draw_offset, gpu_draw_x, gpu_draw_y, gpu_draw_length,
               gpu_cmd_submitted, mem_rd_data, fb_rdata, scan_req, scan_addr,
        input  gpu_ready, gpu_collision, mem_addr, mem_rd_en, fb_addr, fb_we,
               fb_wdata, scan_gnt
    );
endinterface

// File: rtl/gpu_draw_sequencer.sv
// rtl/gpu_draw_sequencer.sv - CHIP-8 CLEAR/DRAW sequencer sharing the framebuffer port with scanout
// Define GPU_SPRITE_WRAP_EN to wrap sprites around the screen edges instead of clipping them.
module gpu_draw_sequencer #(
    parameter int FB_BYTES = 256,
    parameter int MAX_ROWS = 15
) (
    input  logic                clk,
    input  logic                reset,
    gpu_draw_sequencer_if.slave bus
);
    localparam int         ROW_BITS  = $clog2(MAX_ROWS + 1);
    localparam logic [7:0] LAST_ADDR = 8'(FB_BYTES - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_DONE, S_CLEAR, S_FETCH, S_WAIT,
        S_READ_L, S_WRITE_L, S_READ_R, S_WRITE_R
    } state_t;

    state_t              state, state_next;
    logic [15:0]         offset;
    logic [2:0]          shift, col;
    logic [4:0]          y0;
    logic [ROW_BITS-1:0] rows, row_idx;
    logic [7:0]          clr_addr, sprite, old_q;
    logic                rd_pend, collision;

    logic        granted, last_row, row_end, has_right, row_done;
    logic [5:0]  row_sum;
    logic [15:0] shifted;
    logic [7:0]  old_val, part;
    logic [7:0]  seq_addr, seq_wdata;
    logic        seq_we;
    logic        unused_bits;

    assign unused_bits = ^{bus.gpu_draw_x[7:6], bus.gpu_draw_y[7:5], bus.gpu_draw_length[7:ROW_BITS]};

    assign granted  = !bus.scan_req;
    assign row_sum  = 6'(y0) + 6'(row_idx);
    assign last_row = (row_idx + ROW_BITS'(1)) == rows;
`ifdef GPU_SPRITE_WRAP_EN
    assign has_right = (shift != 3'd0);
    assign row_end   = last_row;
`else
    logic [5:0] next_sum;
    assign next_sum  = row_sum + 6'd1;
    assign has_right = (shift != 3'd0) && (col != 3'd7);
    assign row_end   = last_row || next_sum[5];
`endif
    // Upper byte lands in the left column, spill-over bits in the right one.
    assign shifted  = {sprite, 8'h00} >> shift;
    assign part     = (state == S_WRITE_R) ? shifted[7:0] : shifted[15:8];
    assign old_val  = rd_pend ? bus.fb_rdata : old_q;
    assign row_done = ((state == S_WRITE_L) && !has_right) || (state == S_WRITE_R);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: if (bus.gpu_cmd_submitted) begin
                if (bus.gpu_cmd == 4'd1)
                    state_next = S_CLEAR;
                else if (bus.gpu_cmd == 4'd2 && bus.gpu_draw_length[ROW_BITS-1:0] != '0)
                    state_next = S_FETCH;
                else
                    state_next = S_DONE;
            end
            S_DONE:    state_next = S_IDLE;
            S_CLEAR:   if (granted && clr_addr == LAST_ADDR) state_next = S_IDLE;
            S_FETCH:   state_next = S_WAIT;
            S_WAIT:    state_next = S_READ_L;
            S_READ_L:  if (granted) state_next = S_WRITE_L;
            S_WRITE_L: if (granted) state_next = has_right ? S_READ_R : (row_end ? S_IDLE : S_FETCH);
            S_READ_R:  if (granted) state_next = S_WRITE_R;
            S_WRITE_R: if (granted) state_next = row_end ? S_IDLE : S_FETCH;
            default:   state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            offset    <= '0;
            shift     <= '0;
            col       <= '0;
            y0        <= '0;
            rows      <= '0;
            row_idx   <= '0;
            clr_addr  <= '0;
            sprite    <= '0;
            old_q     <= '0;
            rd_pend   <= 1'b0;
            collision <= 1'b0;
        end else begin
            // Read data is taken one cycle after our own read even if scanout owns the port now.
            rd_pend <= ((state == S_READ_L) || (state == S_READ_R)) && granted;
            if (rd_pend) old_q <= bus.fb_rdata;
            if (state == S_IDLE && bus.gpu_cmd_submitted) begin
                offset   <= bus.gpu_draw_offset;
                shift    <= bus.gpu_draw_x[2:0];
                col      <= bus.gpu_draw_x[5:3];
                y0       <= bus.gpu_draw_y[4:0];
                rows     <= bus.gpu_draw_length[ROW_BITS-1:0];
                row_idx  <= '0;
                clr_addr <= '0;
                if (bus.gpu_cmd == 4'd2) collision <= 1'b0;
            end
            if (state == S_CLEAR && granted) clr_addr <= clr_addr + 8'd1;
            if (state == S_WAIT) sprite <= bus.mem_rd_data;
            if (((state == S_WRITE_L) || (state == S_WRITE_R)) && granted) begin
                if ((old_val & part) != 8'h00) collision <= 1'b1;
                if (row_done) row_idx <= row_idx + ROW_BITS'(1);
            end
        end
    end

    always_comb begin
        seq_addr  = 8'h00;
        seq_wdata = 8'h00;
        seq_we    = 1'b0;
        case (state)
            S_CLEAR: begin
                seq_addr = clr_addr;
                seq_we   = 1'b1;
            end
            S_READ_L:  seq_addr = {row_sum[4:0], col};
            S_WRITE_L: begin
                seq_addr  = {row_sum[4:0], col};
                seq_wdata = old_val ^ part;
                seq_we    = 1'b1;
            end
            S_READ_R:  seq_addr = {row_sum[4:0], col + 3'd1};
            S_WRITE_R: begin
                seq_addr  = {row_sum[4:0], col + 3'd1};
                seq_wdata = old_val ^ part;
                seq_we    = 1'b1;
            end
            default: ;
        endcase
        bus.gpu_ready     = (state == S_IDLE);
        bus.gpu_collision = collision;
        bus.mem_rd_en     = (state == S_FETCH);
        bus.mem_addr      = (state == S_FETCH) ? offset + 16'(row_idx) : 16'h0000;
        bus.scan_gnt      = bus.scan_req;
        bus.fb_addr       = bus.scan_req ? bus.scan_addr : seq_addr;
        bus.fb_we         = seq_we && !bus.scan_req;
        bus.fb_wdata      = seq_wdata;
    end
endmodule

// File: tb/tb_gpu_draw_sequencer.sv
// tb/tb_gpu_draw_sequencer.sv - self-checking bench for gpu_draw_sequencer against a pixel-level model
module tb_gpu_draw_sequencer;
    logic clk;
    logic reset;
    gpu_draw_sequencer_if bus();

    gpu_draw_sequencer dut (.clk(clk), .reset(reset), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0]  fb  [0:255];
    logic [7:0]  mfb [0:255];
    logic [7:0]  mem [0:65535];
    logic [15:0] wq[$];
    logic [15:0] ew[$];
    int vectors = 0, errors = 0;
    int scan_delay = 0, scan_hold = 0, scan_viol = 0;
    bit scan_rand = 0;

    // Framebuffer RAM and sprite memory, both with one cycle of read latency.
    always @(posedge clk) begin
        if (bus.fb_we) begin
            fb[bus.fb_addr] <= bus.fb_wdata;
            wq.push_back({bus.fb_addr, bus.fb_wdata});
        end
        bus.fb_rdata <= fb[bus.fb_addr];
        if (bus.mem_rd_en) bus.mem_rd_data <= mem[bus.mem_addr];
        if (bus.scan_req && (bus.fb_we || !bus.scan_gnt || bus.fb_addr !== bus.scan_addr))
            scan_viol++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk); #1;
        if (scan_delay > 0) begin scan_delay--; bus.scan_req = 1'b0; end
        else if (scan_hold > 0) begin scan_hold--; bus.scan_req = 1'b1; end
        else bus.scan_req = scan_rand ? ($urandom_range(0, 3) == 0) : 1'b0;
        bus.scan_addr = 8'($urandom);
    endtask

    task automatic submit(input logic [3:0] cmd, input logic [15:0] off,
                          input logic [7:0] x, input logic [7:0] y, input logic [7:0] len);
        bus.gpu_cmd = cmd; bus.gpu_draw_offset = off;
        bus.gpu_draw_x = x; bus.gpu_draw_y = y; bus.gpu_draw_length = len;
        bus.gpu_cmd_submitted = 1'b1;
        tick;
        bus.gpu_cmd_submitted = 1'b0;
    endtask

    task automatic wait_ready(input int pulse_at, output int k);
        k = 1;
        while (!bus.gpu_ready && k < 2000) begin
            if (k == pulse_at) begin
                bus.gpu_cmd = 4'd2; bus.gpu_draw_length = 8'h03; bus.gpu_cmd_submitted = 1'b1;
            end
            tick;
            bus.gpu_cmd_submitted = 1'b0;
            k++;
        end
        check("ready_timeout", bus.gpu_ready, 1);
    endtask

    // Pixel-by-pixel XOR on screen coordinates; byte packing is derived, not copied.
    task automatic model_draw(input logic [15:0] off, input logic [7:0] x, input logic [7:0] y,
                              input logic [7:0] len, output logic coll);
        int x0, y0, n, py, px, idx, bp;
        logic [7:0]  b;
        logic [15:0] a;
        x0 = x % 64; y0 = y % 32; n = len % 16; coll = 0;
        for (int i = 0; i < n; i++) begin
            py = y0 + i;
`ifdef GPU_SPRITE_WRAP_EN
            py = py % 32;
`else
            if (py >= 32) break;
`endif
            a = off + 16'(i);
            b = mem[a];
            for (int k = 0; k < 8; k++) begin
                if (!b[7-k]) continue;
                px = x0 + k;
`ifdef GPU_SPRITE_WRAP_EN
                px = px % 64;
`else
                if (px >= 64) continue;
`endif
                idx = py * 8 + px / 8;
                bp  = 7 - (px % 8);
                if (mfb[idx][bp]) coll = 1;
                mfb[idx][bp] = ~mfb[idx][bp];
            end
        end
    endtask

    task automatic check_fb(input string tag);
        int bad = 0;
        for (int i = 0; i < 256; i++) if (fb[i] !== mfb[i]) bad++;
        check(tag, bad, 0);
    endtask

    task automatic check_writes(input string tag);
        int bad;
        bad = (wq.size() != ew.size()) ? 1 : 0;
        for (int i = 0; i < wq.size() && i < ew.size(); i++) if (wq[i] !== ew[i]) bad++;
        check(tag, bad, 0);
    endtask

    task automatic check_clear(input string tag, input int pulse_at);
        int k, bad;
        wq.delete();
        submit(4'd1, 16'h0, 8'h0, 8'h0, 8'h0);
        wait_ready(pulse_at, k);
        check({tag, "_latency"}, k, 257);
        bad = (wq.size() != 256) ? 1 : 0;
        for (int i = 0; i < wq.size(); i++) if (wq[i] !== {8'(i), 8'h00}) bad++;
        check({tag, "_trace"}, bad, 0);
        for (int i = 0; i < 256; i++) mfb[i] = 8'h00;
        check_fb({tag, "_fb"});
    endtask

    task automatic do_draw(input string tag, input logic [15:0] off, input logic [7:0] x,
                           input logic [7:0] y, input logic [7:0] len, input int exp_lat);
        int k;
        logic coll;
        wq.delete();
        model_draw(off, x, y, len, coll);
        submit(4'd2, off, x, y, len);
        check({tag, "_busy"}, bus.gpu_ready, 0);
        wait_ready(0, k);
        if (exp_lat > 0) check({tag, "_latency"}, k, exp_lat);
        check({tag, "_coll"}, bus.gpu_collision, coll);
        check_fb({tag, "_fb"});
    endtask

    initial begin
        logic [15:0] off;
        logic coll_before;
        int k;
        reset = 1'b1;
        bus.gpu_cmd = 0; bus.gpu_draw_offset = 0; bus.gpu_draw_x = 0; bus.gpu_draw_y = 0;
        bus.gpu_draw_length = 0; bus.gpu_cmd_submitted = 0; bus.scan_req = 0; bus.scan_addr = 0;
        for (int i = 0; i < 256; i++) fb[i] = 8'($urandom);
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", bus.gpu_ready, 1);
        check("rst_coll", bus.gpu_collision, 0);
        check("rst_we", bus.fb_we, 0);
        check("rst_rd_en", bus.mem_rd_en, 0);
        check("rst_mem_addr", bus.mem_addr, 0);
        check("rst_wdata", bus.fb_wdata, 0);
        reset = 1'b0;
        tick;

        check_clear("clear", 0);
        check("clear_coll", bus.gpu_collision, 0);

        mem[16'h0200] = 8'hF0;
        do_draw("draw_a", 16'h0200, 8'd0, 8'd0, 8'd1, 5);
        ew = '{16'h00F0}; check_writes("draw_a_trace");
        check("draw_a_coll0", bus.gpu_collision, 0);
        do_draw("draw_b", 16'h0200, 8'd0, 8'd0, 8'd1, 5);
        ew = '{16'h0000}; check_writes("draw_b_trace");
        check("draw_b_coll1", bus.gpu_collision, 1);

        do_draw("draw_n0", 16'h0200, 8'd3, 8'd3, 8'h10, 2);
        check("draw_n0_trace", wq.size(), 0);

        submit(4'd0, 16'h0, 8'h0, 8'h0, 8'h0);
        check("nop_busy", bus.gpu_ready, 0);
        tick;
        check("nop_ready", bus.gpu_ready, 1);

        mem[16'h0300] = 8'hFF;
        do_draw("draw_x4", 16'h0300, 8'd4, 8'd1, 8'd1, 7);
        ew = '{16'h080F, 16'h09F0}; check_writes("draw_x4_trace");

        for (int i = 0; i < 3; i++) mem[16'h0400 + 16'(i)] = 8'hFF;
        do_draw("draw_edge", 16'h0400, 8'd62, 8'd30, 8'd3, -1);
`ifdef GPU_SPRITE_WRAP_EN
        ew = '{16'hF703, 16'hF0FC, 16'hFF03, 16'hF8FC, 16'h0703, 16'h00FC};
`else
        ew = '{16'hF703, 16'hFF03};
`endif
        check_writes("draw_edge_trace");

        mem[16'h0500] = 8'hA5; mem[16'h0501] = 8'h3C;
        scan_viol = 0; scan_delay = 2; scan_hold = 10;
        do_draw("draw_scan", 16'h0500, 8'd13, 8'd5, 8'd2, 23);
        check("draw_scan_viol", scan_viol, 0);

        wq.delete();
        submit(4'd1, 16'h0, 8'h0, 8'h0, 8'h0);
        k = 0;
        while (!(bus.fb_we && bus.fb_addr == 8'h40) && k < 400) begin tick; k++; end
        check("rst_mid_reach", {31'd0, bus.fb_we && bus.fb_addr == 8'h40}, 1);
        reset = 1'b1;
        #1;
        check("rst_mid_ready", bus.gpu_ready, 1);
        check("rst_mid_we", bus.fb_we, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        tick;
        coll_before = bus.gpu_collision;
        submit(4'd0, 16'h0, 8'h0, 8'h0, 8'h0);
        check("rst_nop_busy", bus.gpu_ready, 0);
        tick;
        check("rst_nop_ready", bus.gpu_ready, 1);
        check_clear("reclear", 100);
        check("reclear_coll", bus.gpu_collision, coll_before);

        scan_rand = 1;
        for (int t = 0; t < 24; t++) begin
            off = 16'($urandom);
            for (int i = 0; i < 16; i++) mem[off + 16'(i)] = 8'($urandom);
            do_draw("rand", off, 8'($urandom), 8'($urandom), 8'($urandom), -1);
        end
        scan_rand = 0;
        check("rand_scan_viol", scan_viol, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/gpu_draw_sequencer.md
Name: gpu_draw_sequencer

Overview:
- Controller that executes GPU commands (CLEAR, DRAW) against the 64x32 1bpp framebuffer.
- Sequences sprite fetches from main memory and read-XOR-write of framebuffer bytes, and computes the collision flag.
- Shares the single framebuffer RAM port with display scanout. Scanout has absolute priority.
- Sits between the CPU command interface and the framebuffer/memory ports.

Parameters:
- FB_BYTES, 256, framebuffer size in bytes (8 bytes per row x 32 rows); fixed for CHIP-8.
- MAX_ROWS, 15, maximum sprite rows; only cmd_length[3:0] is used.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- gpu_cmd  in  4  0=NOP, 1=CLEAR, 2=DRAW, others=NOP
- gpu_draw_offset  in  16  sprite base address in main memory
- gpu_draw_x  in  8  sprite X pixel coordinate
- gpu_draw_y  in  8  sprite Y pixel coordinate
- gpu_draw_length  in  8  sprite rows; bits [3:0] used
- gpu_cmd_submitted  in  1  command valid strobe
- gpu_ready  out  1  idle, able to accept a command
- gpu_collision  out  1  result of last DRAW
- mem_addr  out  16  sprite read address
- mem_rd_en  out  1  sprite read strobe; data returns 1 cycle later
- mem_rd_data  in  8  sprite byte
- fb_addr  out  8  framebuffer byte address ({row[4:0], col[2:0]})
- fb_we  out  1  framebuffer write enable
- fb_wdata  out  8  framebuffer write data, MSB = leftmost pixel
- fb_rdata  in  8  framebuffer read data, 1-cycle latency
- scan_req  in  1  scanout requests the framebuffer port this cycle
- scan_addr  in  8  scanout byte address
- scan_gnt  out  1  equals scan_req; scanout owns the port this cycle

Behaviour:
- Reset values (asynchronous): state IDLE, gpu_ready=1, gpu_collision=0, mem_rd_en=0, fb_we=0, mem_addr=0, fb_wdata=0.
- Reset mid-command aborts the command immediately. Framebuffer contents may be partially updated; no recovery.
- Accept: rising edge with gpu_submitted && gpu_ready.
  - All cmd inputs are latched; gpu_ready=0 from the next cycle.
  - A submit while busy is ignored.
  - NOP returns gpu_ready=1 one cycle after accept.
- Arbitration:
  - scan_req=1: fb_addr=scan_addr, fb_we=0, sequencer FB access stalls (state frozen).
  - Sequencer FB reads/writes occur only in cycles with scan_req=0.
  - A pending-read flag captures fb_rdata exactly 1 cycle after the sequencer's own read, regardless of scan_req in that cycle.
- CLEAR:
  - Writes 0x00 to addresses 0..255 in ascending order, one per granted cycle.
  - gpu_ready=1 the cycle after the write to address 255.
  - Uncontended latency is 257 cycles from accept to ready.
  - gpu_collision is unchanged.
- DRAW:
  - gpu_collision cleared on accept.
  - Start coordinates: x0 = x mod 64, y0 = y mod 32, shift s = x0[2:0], column c = x0[5:3].
- DRAW row loop (i = 0..n-1, n = length[3:0]) states:
  - FETCH: mem_addr = offset+i (16-bit wrap), mem_rd_en=1. WAIT: capture sprite byte b.
  - READ_L: read (y0+i, c). WRITE_L: write old ^ (b>>s).
  - READ_R and WRITE_R (only if s!=0): read/write (y0+i, c+1) with old ^ (b<<(8-s)).
  - NEXT: increment i.
- Collision: set if (old & shifted_part) != 0 for any byte written. It is sticky for the command.
- Clipping (default):
  - Rows with y0+i >= 32 are skipped and the command ends.
  - The right byte is skipped when c==7.
- n=0: no accesses, gpu_collision=0, ready 2 cycles after accept.
- gpu_ready rises in the cycle after the final write. gpu_collision is valid from that same cycle and held until the next DRAW accept.

Optional Feature:
- GPU_SPRITE_WRAP_EN defined: rows use (y0+i) mod 32; the right byte uses column (c+1) mod 8. No clipping occurs.
- Undefined: the clipping rules above apply.

Test Plan:
- Reset, then CLEAR with scan_req=0 -> 256 writes of 0x00 to addresses 0..255 in order, gpu_ready=1 at cycle 257, collision unchanged.
- DRAW x=0,y=0,len=1, mem[0x200]=0xF0 on a cleared FB -> single write addr 0x00 data 0xF0, collision=0. Repeat the same DRAW -> addr 0x00 data 0x00, collision=1.
- DRAW x=4,y=1,len=1, byte 0xFF -> addr 0x08 gets 0x0F, addr 0x09 gets 0xF0, collision=0.
- DRAW x=62,y=30,len=3, bytes 0xFF:
  - Default: writes to 0xF7 (0x03) and 0xFF (0x03) only.
  - With GPU_SPRITE_WRAP_EN: also 0xF0/0xF8 (0xFC) and row 0 at 0x07/0x00.
- scan_req held high 10 cycles during a DRAW -> no sequencer fb_we in those cycles, scan_gnt=1, final FB contents identical to the uncontended run.
- Assert reset mid-CLEAR at address 0x40 -> gpu_ready=1, fb_we=0 immediately. A new submit is then accepted normally.
